// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that merges two writeback sources onto the single register file write port.
// Optional read forwarding across the write cycle is built when RF_WRITE_ARBITER_FWD_EN is defined.
module rf_write_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  output logic              req1_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [WIDTH-1:0]  wd3,
  output logic [7:0]        conflict_cnt
`ifdef RF_WRITE_ARBITER_FWD_EN
  ,
  input  logic [ADDR_W-1:0] ra,
  input  logic [WIDTH-1:0]  rd_in,
  output logic [WIDTH-1:0]  rd_out
`endif
);

  logic prio;
  logic xfer0;
  logic xfer1;

  always_comb begin
    req0_ready = !req1_valid || !prio;
    req1_ready = !req0_valid || prio;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
  end

  // When both are valid exactly one ready is high, so xfer0 and xfer1 never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3  <= 1'b0;
      wa3  <= '0;
      wd3  <= '0;
      prio <= 1'b0;
    end else if (xfer0) begin
      we3  <= (req0_addr != '0);
      wa3  <= req0_addr;
      wd3  <= req0_data;
      prio <= 1'b1;
    end else if (xfer1) begin
      we3  <= (req1_addr != '0);
      wa3  <= req1_addr;
      wd3  <= req1_data;
      prio <= 1'b0;
    end else begin
      we3  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 8'd0;
    end else if (req0_valid && req1_valid && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

`ifdef RF_WRITE_ARBITER_FWD_EN
  // Covers the half cycle before the register file commits the pending write.
  always_comb begin
    rd_out = rd_in;
    if (we3 && (wa3 == ra) && (ra != '0)) begin
      rd_out = wd3;
    end
  end
`endif

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Two-requester, round-robin arbiter that shares the register file's single write port (we3/wa3/wd3) between two write sources, e.g. the execute writeback path and a load/debug writeback path. It accepts one write per cycle over a valid/ready handshake and registers it onto the write port. It suppresses writes to register 0 and counts contention cycles. It sits between the datapath writeback sources and the register file, whose write port captures on the falling clock edge.

## Interface
Parameters:
- WIDTH, 8: data width; matches the register file data width.
- ADDR_W, 5: register address width (32 registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 is granted this cycle; combinational.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- we3  out  1  register file write enable; registered.
- wa3  out  ADDR_W  register file write address; registered.
- wd3  out  WIDTH  register file write data; registered.
- conflict_cnt  out  8  saturating count of cycles in which both requests were valid.

## Operation
- Internal priority pointer prio: 0 favours req0, 1 favours req1.
- Ready logic:
  - req0_ready = !req1_valid || prio==0.
  - req1_ready = !req0_valid || prio==1.
  - Exactly one requester is ready when both are valid.
- Transfer: reqN_valid && reqN_ready at a rising edge.
- Requesters hold valid/addr/data stable until transfer. The arbiter never withdraws ready from a valid requester within a cycle.
- On a transfer:
  - wa3 <= addr, wd3 <= data.
  - we3 <= (addr != 0). A write to r0 is accepted and consumed but never enabled.
  - prio <= index of the other requester.
- No transfer: we3 <= 0; wa3 and wd3 hold their values; prio holds.
- prio changes only on a transfer. A lone requester always wins and still flips prio.
- conflict_cnt increments on every rising edge with req0_valid && req1_valid. It saturates at 255, then holds until reset.
- Reset values: we3=0, wa3=0, wd3=0, prio=0, conflict_cnt=0. Reset asserted mid-operation clears we3 immediately and asynchronously, so no write reaches the register file.

## Timing
- Accept latency: 0 cycles. Ready is combinational from the two valid inputs and prio.
- A request accepted at rising edge N drives we3/wa3/wd3 from edge N until edge N+1. The register file captures it at the falling edge midway through that cycle.
- Data is visible to combinational reads from that falling edge onward.
- Throughput: one write per cycle sustained, alternating requesters under contention.
- Back-to-back writes to the same address from different requesters land in grant order; the last write wins.
- No internal buffering. A request not granted simply waits.

## Configuration
- RF_WRITE_ARBITER_FWD_EN defined adds these ports:
  - ra  in  ADDR_W: read address.
  - rd_in  in  WIDTH: register file read data.
  - rd_out  out  WIDTH: forwarded read data.
- With the macro defined, rd_out = wd3 when we3 && wa3==ra && ra!=0; otherwise rd_out = rd_in. This covers the first half-cycle after edge N, before the register file commits the write.
- Undefined: none of these ports exist, and no forwarding logic is built.

## Test plan
- Reset: hold rst_n=0 with both requests valid -> we3=0, wa3=0, wd3=0, conflict_cnt=0, no write. Release reset -> req0 is granted first (prio=0).
- Single requester: req1 writes addr 5, data 0x3C -> req1_ready=1 in the same cycle; next cycle we3=1, wa3=5, wd3=0x3C; one cycle later we3=0.
- Contention: both valid for 4 cycles with distinct addresses 1..4 -> grants alternate req0, req1, req0, req1; four consecutive we3 pulses; conflict_cnt=4.
- Register 0: req0 writes addr 0, data 0xFF -> req0_ready=1, transfer consumed, we3 stays 0; prio flips to 1.
- Saturation and async reset: both valid for 300 cycles -> conflict_cnt=255 and holds. Drop rst_n mid-cycle while we3=1 -> we3 falls immediately, before the next clock edge.
- With RF_WRITE_ARBITER_FWD_EN: req0 writes r7=0x5A while ra=7 and rd_in=0x00 -> rd_out=0x5A during the we3 cycle. With ra=0 under the same write -> rd_out=rd_in.
